spart_rx_fifo: RTL and testbench
================================

Name: spart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the SPART RX shifter.
- Captures each completed 10-bit frame on the shifter's done pulse and checks the start and stop bits.
- Pushes the 8 data bits into a small first-word-fall-through FIFO; the bus interface pops it.
- Reports data-available, occupancy, sticky overrun and sticky framing-error status to the control/bus logic.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), index width; pointers are PTR_W+1 bits wide, with the extra bit used for wrap.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- rx_done  input  1  frame-complete indication from RX shifter; may stay high for more than one cycle.
- rx_frame  input  10  shifter contents: [0] start, [8:1] data LSB-first, [9] stop.
- rd_en  input  1  pop request from bus side.
- clr_err  input  1  clears the sticky error flags.
- rd_data  output  8  FIFO head byte; fall-through.
- rda  output  1  receive data available (FIFO not empty).
- fifo_count  output  PTR_W+1  current occupancy, 0..DEPTH.
- full  output  1  fifo_count == DEPTH.
- overrun  output  1  sticky: a frame arrived while the FIFO was full.
- framing_err  output  1  sticky: a frame was captured with start!=0 or stop!=1.

Behaviour:
- Reset, asynchronous:
  - wr_ptr = rd_ptr = 0 and rx_done_q = 0.
  - overrun = 0, framing_err = 0, rda = 0, full = 0, fifo_count = 0, rd_data = 8'h00.
  - Storage array is not reset.
- Capture:
  - push_req = rx_done & ~rx_done_q, where rx_done_q is rx_done registered.
  - rx_frame is sampled on that same posedge, so exactly one capture per rx_done assertion regardless of pulse width.
- Frame check at capture:
  - valid = ~rx_frame[0] & rx_frame[9].
  - If not valid: nothing is written and framing_err is set on that posedge.
  - If valid: data = rx_frame[8:1].
- FIFO:
  - Write at mem[wr_ptr[PTR_W-1:0]], then wr_ptr+1; pop increments rd_ptr.
  - Pointers wrap naturally modulo 2*DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and MSBs differ.
  - fifo_count = wr_ptr - rd_ptr, PTR_W+1 bits, unsigned.
- Output timing:
  - rd_data = mem[rd_ptr index] combinationally; the value is meaningful only when rda = 1.
  - rda and fifo_count reflect the registered pointers, so a captured byte is visible the cycle after the capture edge (latency 1).
- Pop:
  - rd_en with rda = 1 advances rd_ptr on the posedge.
  - rd_en while empty is ignored; there is no underflow flag.
- Simultaneous push and pop:
  - When not full and not empty: both take effect and fifo_count is unchanged.
  - When empty: only the push takes effect, and rda rises next cycle.
  - When full: the pop is processed first, so the push is accepted and no overrun is raised.
- Push while full without a pop: overrun is set; the stored data follows the Optional Feature.
- Invalid frame while full: only framing_err is set; overrun is not set.
- Sticky flags:
  - clr_err clears overrun and framing_err on the posedge.
  - If a set condition occurs in the same cycle as clr_err, set wins.
- Reset mid-operation: FIFO contents are logically discarded (count 0), and any in-flight rx_done edge is lost.
- No internal FSM beyond the edge detector; all control is pointer-driven.

Optional Feature:
- Macro: SPART_RX_FIFO_OVERWRITE_EN.
- Defined: a valid push while full without a pop writes at wr_ptr and advances both wr_ptr and rd_ptr. The oldest byte is dropped, the newest is kept, count stays at DEPTH, and overrun is set.
- Undefined (default): a valid push while full is discarded and the pointers are unchanged. The oldest data is kept, and overrun is set.

Test Plan:
- Single valid frame rx_frame=10'b1_10100101_0 with 1-cycle rx_done:
  - Next cycle: rda=1, rd_data=8'hA5, fifo_count=1.
  - rd_en for 1 cycle: rda=0, fifo_count=0.
- rx_done held high 5 cycles with frame 10'b1_00111100_0: exactly one push; fifo_count=1, rd_data=8'h3C.
- Framing errors:
  - Frame 10'b0_11110000_0 (stop low): nothing pushed, framing_err=1.
  - Frame 10'b1_00000001_1 (start high): nothing pushed, framing_err stays 1.
  - clr_err concurrent with a new bad frame: framing_err stays 1.
  - clr_err alone: framing_err=0.
- Fill DEPTH=4 with 8'h01..8'h04, then push 8'h05 with no pop:
  - Default: full=1, overrun=1, pops return 01,02,03,04.
  - With SPART_RX_FIFO_OVERWRITE_EN: pops return 02,03,04,05.
- Full FIFO, push 8'h06 and rd_en in the same cycle: overrun stays 0, fifo_count stays 4, last entry read is 06.
- Wrap-around:
  - 10 push/pop pairs at DEPTH=4: data order preserved, fifo_count never exceeds 1.
  - Async rst asserted mid-stream: all outputs return to reset values immediately.

Source files
------------

// File: rtl/spart_rx_fifo.sv
// SPART receive FIFO: edge-detected frame capture, start/stop check, FWFT byte FIFO, sticky status.
// Optional SPART_RX_FIFO_OVERWRITE_EN: a push into a full FIFO drops the oldest byte instead of the newest.
`default_nettype none

module spart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_done,
    input  logic [9:0]       rx_frame,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [7:0]       rd_data,
    output logic             rda,
    output logic [PTR_W:0]   fifo_count,
    output logic             full,
    output logic             overrun,
    output logic             framing_err
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           rx_done_q;
    logic           overrun_q, overrun_d;
    logic           framing_err_q, framing_err_d;
    logic [7:0]     mem_q [DEPTH];

    logic empty_w, full_w, push_req_w, frame_ok_w, push_ok_w, pop_w, wr_en_w;
    logic ovr_set_w, ferr_set_w;

    always_comb begin
        empty_w    = (wr_ptr_q == rd_ptr_q);
        full_w     = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                     (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
        push_req_w = rx_done & ~rx_done_q;
        frame_ok_w = ~rx_frame[0] & rx_frame[9];
        push_ok_w  = push_req_w & frame_ok_w;
        pop_w      = rd_en & ~empty_w;
        ovr_set_w  = push_ok_w & full_w & ~pop_w;
        ferr_set_w = push_req_w & ~frame_ok_w;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
`ifdef SPART_RX_FIFO_OVERWRITE_EN
        // Full with no pop: write over the oldest slot and slide the read pointer with it.
        wr_en_w    = push_ok_w;
        if (pop_w || ovr_set_w) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
`else
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        wr_en_w    = push_ok_w & (~full_w | pop_w);
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
`endif
        if (wr_en_w) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        overrun_d     = ovr_set_w  | (overrun_q & ~clr_err);
        framing_err_d = ferr_set_w | (framing_err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rx_done_q     <= 1'b0;
            overrun_q     <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rx_done_q     <= rx_done;
            overrun_q     <= overrun_d;
            framing_err_q <= framing_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_w) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= rx_frame[8:1];
        end
    end

    // Storage is never reset, so the head byte is forced to zero while empty.
    assign rd_data     = empty_w ? 8'h00 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign rda         = ~empty_w;
    assign full        = full_w;
    assign fifo_count  = wr_ptr_q - rd_ptr_q;
    assign overrun     = overrun_q;
    assign framing_err = framing_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spart_rx_fifo.sv
// Self-checking bench for spart_rx_fifo: queue-based reference model, directed cases and random traffic.
`default_nettype none

module tb_spart_rx_fifo;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rx_done = 1'b0;
    logic [9:0]       rx_frame = '0;
    logic             rd_en = 1'b0;
    logic             clr_err = 1'b0;
    logic [7:0]       rd_data;
    logic             rda;
    logic [PTR_W:0]   fifo_count;
    logic             full;
    logic             overrun;
    logic             framing_err;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    logic [7:0] m_q[$];
    bit         m_prev = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;

    spart_rx_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_frame(rx_frame),
        .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data), .rda(rda),
        .fifo_count(fifo_count), .full(full), .overrun(overrun),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rda", rda, m_q.size() != 0);
            chk("fifo_count", fifo_count, m_q.size());
            chk("full", full, m_q.size() == DEPTH);
            chk("overrun", overrun, m_ovr);
            chk("framing_err", framing_err, m_ferr);
            if (m_q.size() != 0) chk("rd_data", rd_data, m_q[0]);
        end
    end

    function automatic logic [9:0] good(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // One clock: apply inputs, predict from the queue model, commit the prediction after the edge.
    task automatic cycle(input logic d, input logic [9:0] f, input logic r, input logic c);
        logic [7:0] qn[$];
        bit edge_v, ok, so, sf;
        rx_done = d; rx_frame = f; rd_en = r; clr_err = c;
        qn = m_q;
        edge_v = d && !m_prev;
        ok = !f[0] && f[9];
        so = 1'b0;
        sf = edge_v && !ok;
        if (r && qn.size() != 0) void'(qn.pop_front());
        if (edge_v && ok) begin
            if (qn.size() < DEPTH) begin
                qn.push_back(f[8:1]);
            end else begin
                so = 1'b1;
`ifdef SPART_RX_FIFO_OVERWRITE_EN
                void'(qn.pop_front());
                qn.push_back(f[8:1]);
`endif
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_q = qn;
            m_prev = d;
            m_ovr = so || (m_ovr && !c);
            m_ferr = sf || (m_ferr && !c);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic [9:0] f);
        cycle(1'b1, f, 1'b0, 1'b0);
        cycle(1'b0, f, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        chk("rst_rda", rda, 1'b0);
        chk("rst_count", fifo_count, 0);
        chk("rst_full", full, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_ferr", framing_err, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        @(negedge clk);
        #1;
        rst = 1'b1;
        cmp_en = 1'b1;

        cycle(1'b1, 10'b1_10100101_0, 1'b0, 1'b0);
        chk("a5_rda", rda, 1'b1);
        chk("a5_data", rd_data, 8'hA5);
        chk("a5_count", fifo_count, 1);
        cycle(1'b0, 10'b0, 1'b1, 1'b0);
        chk("a5_pop_rda", rda, 1'b0);
        chk("a5_pop_count", fifo_count, 0);

        for (int i = 0; i < 5; i++) cycle(1'b1, 10'b1_00111100_0, 1'b0, 1'b0);
        cycle(1'b0, 10'b0, 1'b0, 1'b0);
        chk("hold_count", fifo_count, 1);
        chk("hold_data", rd_data, 8'h3C);
        cycle(1'b0, 10'b0, 1'b1, 1'b0);

        pulse(10'b0_11110000_0);
        chk("stop_low_ferr", framing_err, 1'b1);
        chk("stop_low_count", fifo_count, 0);
        pulse(10'b1_00000001_1);
        chk("start_high_ferr", framing_err, 1'b1);
        chk("start_high_count", fifo_count, 0);
        cycle(1'b1, 10'b0_00000000_0, 1'b0, 1'b1);
        chk("clr_vs_set_ferr", framing_err, 1'b1);
        cycle(1'b0, 10'b0, 1'b0, 1'b1);
        chk("clr_ferr", framing_err, 1'b0);

        for (int i = 1; i <= 4; i++) pulse(good(8'(i)));
        pulse(good(8'h05));
        chk("ovf_full", full, 1'b1);
        chk("ovf_overrun", overrun, 1'b1);
        for (int i = 0; i < 4; i++) begin
`ifdef SPART_RX_FIFO_OVERWRITE_EN
            chk("ovf_pop_data", rd_data, 8'(i + 2));
`else
            chk("ovf_pop_data", rd_data, 8'(i + 1));
`endif
            cycle(1'b0, 10'b0, 1'b1, 1'b0);
        end
        cycle(1'b0, 10'b0, 1'b0, 1'b1);

        for (int i = 1; i <= 4; i++) pulse(good(8'(i)));
        cycle(1'b1, good(8'h06), 1'b1, 1'b0);
        chk("pp_full_overrun", overrun, 1'b0);
        chk("pp_full_count", fifo_count, 4);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("pp_last_data", rd_data, 8'h06);
            cycle(1'b0, 10'b0, 1'b1, 1'b0);
        end

        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, good(8'(8'h40 + i)), 1'b0, 1'b0);
            chk("wrap_data", rd_data, 8'(8'h40 + i));
            chk("wrap_cnt_le1", fifo_count <= 1, 1'b1);
            cycle(1'b0, 10'b0, 1'b1, 1'b0);
            chk("wrap_cnt_le1", fifo_count <= 1, 1'b1);
        end

        for (int i = 0; i < 500; i++) begin
            logic [9:0] f;
            f = {($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, 8'($urandom),
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0};
            cycle($urandom_range(0, 2) == 0, f, $urandom_range(0, 4) < 2,
                  $urandom_range(0, 19) == 0);
        end

        pulse(good(8'h77));
        pulse(good(8'h78));
        rst = 1'b0;
        m_q.delete();
        m_prev = 1'b0;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        #1;
        chk("arst_rda", rda, 1'b0);
        chk("arst_count", fifo_count, 0);
        chk("arst_full", full, 1'b0);
        chk("arst_overrun", overrun, 1'b0);
        chk("arst_ferr", framing_err, 1'b0);
        chk("arst_rd_data", rd_data, 8'h00);
        cycle(1'b0, 10'b0, 1'b0, 1'b0);
        cycle(1'b0, 10'b0, 1'b0, 1'b0);
        rst = 1'b1;
        pulse(good(8'h99));
        chk("post_rst_data", rd_data, 8'h99);
        cycle(1'b0, 10'b0, 1'b1, 1'b0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
